// File: rtl/decoder_sel_gen.sv
// decoder_sel_gen
// ---------------------------------------------------------------------------
// Registered 2-bit select-code sequencer feeding a 2-to-4 decoder, so the
// decoder's one-hot outputs d0..d3 scan in order. Supports free-run scanning
// at a programmable prescale rate, single-step, direction control and a
// direct load.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   rst      in  1  asynchronous, active-high reset
//   en       in  1  run enable: free-run scanning, one advance per DIV cycles
//   dir      in  1  0 = count up (00->01->10->11), 1 = count down
//   step     in  1  single-step request, rising edge only, ignored while en=1
//   load     in  1  synchronous load of load_val, highest priority
//   load_val in  2  value to load (bit1 -> i0, bit0 -> i1)
//   i0       out 1  select MSB to decoder
//   i1       out 1  select LSB to decoder
//   tick     out 1  one-cycle pulse in the cycle a new code first appears
//   wrap     out 1  pulse with tick when the code wraps (11->00 / 00->11)
// ---------------------------------------------------------------------------
module decoder_sel_gen #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic       i0,
  output logic       i1,
  output logic       tick,
  output logic       wrap
);

  // Prescaler width; a single bit is kept even when DIV=1 so the counter
  // always exists (it simply stays at zero).
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [1:0]    code_reg, code_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          step_d_reg;
  logic          tick_reg, tick_next;
  logic          wrap_reg, wrap_next;

  logic [1:0]    code_adv;
  logic          will_wrap;
  logic          step_rise;

  // Neighbouring code in the selected direction; mod-4 wrap is implicit in
  // the 2-bit arithmetic.
  assign code_adv  = dir ? (code_reg - 2'd1) : (code_reg + 2'd1);
  assign will_wrap = dir ? (code_reg == 2'b00) : (code_reg == 2'b11);
  assign step_rise = step & ~step_d_reg;

  always_comb begin
    code_next = code_reg;
    cnt_next  = cnt_reg;
    tick_next = 1'b0;
    wrap_next = 1'b0;
    if (load) begin
      // Load overrides everything, including a pending step edge or a
      // terminal count in the same cycle.
      code_next = load_val;
      cnt_next  = '0;
    end else if (en) begin
      if (cnt_reg == CNT_MAX) begin
        code_next = code_adv;
        cnt_next  = '0;
        tick_next = 1'b1;
        wrap_next = will_wrap;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end else if (step_rise) begin
      code_next = code_adv;
      cnt_next  = '0;
      tick_next = 1'b1;
      wrap_next = will_wrap;
    end
    // Otherwise hold: with en=0 the prescaler freezes so a later run
    // resumes from where it stopped.
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg   <= 2'b00;
      cnt_reg    <= '0;
      step_d_reg <= 1'b0;
      tick_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      code_reg   <= code_next;
      cnt_reg    <= cnt_next;
      // Step history updates unconditionally, so an edge seen during load
      // or run mode is consumed rather than deferred.
      step_d_reg <= step;
      tick_reg   <= tick_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign i0   = code_reg[1];
  assign i1   = code_reg[0];
  assign tick = tick_reg;
  assign wrap = wrap_reg;

endmodule
